// File: rtl/serial_adder_pkg.sv
// Shared types and sizing for the bit-serial adder.
package serial_adder_pkg;

  localparam int WIDTH_DEFAULT = 8;
  localparam int CNT_W_DEFAULT = $clog2(WIDTH_DEFAULT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit combinational full adder: C = majority(X,Y,Z), S = X^Y^Z.
module full_adder_cell (
  input  logic X,
  input  logic Y,
  input  logic Z,
  output logic C,
  output logic S
);

  assign S = X ^ Y ^ Z;
  assign C = (X & Y) | (X & Z) | (Y & Z);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one sum bit per clock through one full-adder cell,
// WIDTH cycles from accepted start to the done pulse.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam int ACC_W = WIDTH - 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [ACC_W-1:0] acc;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_c;
  logic             fa_s;
  logic             load;
  logic             step;
  logic             last;

  full_adder_cell u_fa (
    .X(sa[0]),
    .Y(sb[0]),
    .Z(carry),
    .C(fa_c),
    .S(fa_s)
  );

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == LAST) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // acc keeps only the WIDTH-1 bits already produced; the final bit joins them at completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa    <= '0;
      sb    <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      if (load) begin
        sa    <= a;
        sb    <= b;
        carry <= cin;
        cnt   <= '0;
        acc   <= '0;
      end else if (step) begin
        sa    <= sa >> 1;
        sb    <= sb >> 1;
        carry <= fa_c;
        cnt   <= cnt + CNT_W'(1);
        acc   <= ACC_W'({fa_s, acc} >> 1);
      end
      if (last) begin
        sum  <= {fa_s, acc};
        cout <= fa_c;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH 8, 2 and 16 plus the full-adder cell.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        start8, cin8, busy8, done8, cout8;
  logic [7:0]  a8, b8, sum8;
  logic        start2, cin2, busy2, done2, cout2;
  logic [1:0]  a2, b2, sum2;
  logic        start16, cin16, busy16, done16, cout16;
  logic [15:0] a16, b16, sum16;
  logic        fx, fy, fz, fc, fs;

  int errors = 0;
  int checks = 0;

  logic [8:0]  q8[$];
  logic [2:0]  q2[$];
  logic [16:0] q16[$];

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
  );

  serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
  );

  full_adder_cell fa_unit (.X(fx), .Y(fy), .Z(fz), .C(fc), .S(fs));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one WIDTH=8 addition, records its expectation, waits (bounded) for done.
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                     output int lat, output int nbusy);
    a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
    q8.push_back({1'b0, ta} + {1'b0, tb} + 9'(tc));
    tick();
    start8 = 1'b0;
    lat = 0;
    nbusy = 0;
    while (done8 !== 1'b1 && lat < 40) begin
      if (busy8 === 1'b1) nbusy++;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    logic [9:0] got;
    rst = 1'b1;
    start8 = 0; a8 = 0; b8 = 0; cin8 = 0;
    start2 = 0; a2 = 0; b2 = 0; cin2 = 0;
    start16 = 0; a16 = 0; b16 = 0; cin16 = 0;
    fx = 0; fy = 0; fz = 0;
    #12;
    got = {busy8, done8, sum8};
    checks++;
    if (got !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs: busy/done/sum got %h want 000", got);
    end
    checks++;
    if (cout8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_cout: got %b want 0", cout8);
    end
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_full_adder();
    logic [1:0] e;
    for (int i = 0; i < 8; i++) begin
      {fx, fy, fz} = 3'(i);
      #1;
      e = 2'(fx) + 2'(fy) + 2'(fz);
      checks++;
      if ({fc, fs} !== e) begin
        errors++;
        $display("FAIL fa_cell xyz=%0d: got C,S=%b%b want %b", i, fc, fs, e);
      end
    end
  endtask

  task automatic test_basic();
    int lat, nb;
    logic [8:0] exp;
    op8(8'h05, 8'h03, 1'b0, lat, nb);
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL basic_latency: got %0d want 8", lat);
    end
    checks++;
    if (nb !== 8) begin
      errors++;
      $display("FAIL basic_busy_cycles: got %0d want 8", nb);
    end
    exp = q8.pop_front();
    checks++;
    if ({cout8, sum8} !== exp) begin
      errors++;
      $display("FAIL basic_sum: got %h want %h", {cout8, sum8}, exp);
    end
    checks++;
    if (busy8 !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_with_done: got %b want 0", busy8);
    end
    tick();
    checks++;
    if (done8 !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_width: got %b want 0", done8);
    end
  endtask

  task automatic test_wrap();
    int lat, nb;
    logic [8:0] exp;
    op8(8'hFF, 8'h01, 1'b0, lat, nb);
    exp = q8.pop_front();
    checks++;
    if ({cout8, sum8} !== exp || lat !== 8) begin
      errors++;
      $display("FAIL wrap_ff_01: got %h lat %0d want %h lat 8", {cout8, sum8}, lat, exp);
    end
    tick();
    op8(8'hFF, 8'hFF, 1'b1, lat, nb);
    exp = q8.pop_front();
    checks++;
    if ({cout8, sum8} !== exp || lat !== 8) begin
      errors++;
      $display("FAIL wrap_ff_ff_c: got %h lat %0d want %h lat 8", {cout8, sum8}, lat, exp);
    end
    tick();
  endtask

  task automatic test_start_while_busy();
    int lat, nd;
    logic [8:0] exp, prev;
    prev = {cout8, sum8};
    a8 = 8'h22; b8 = 8'h33; cin8 = 1'b0; start8 = 1'b1;
    q8.push_back(9'h055);
    tick();
    start8 = 1'b0;
    tick();
    tick();
    start8 = 1'b1; a8 = 8'h11; b8 = 8'h00;
    tick();
    start8 = 1'b0;
    checks++;
    if ({cout8, sum8} !== prev) begin
      errors++;
      $display("FAIL busy_hold_prev: got %h want %h", {cout8, sum8}, prev);
    end
    lat = 3;
    while (done8 !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL busy_latency: got %0d want 8", lat);
    end
    exp = q8.pop_front();
    checks++;
    if ({cout8, sum8} !== exp) begin
      errors++;
      $display("FAIL busy_sum: got %h want %h", {cout8, sum8}, exp);
    end
    nd = 0;
    repeat (20) begin
      tick();
      if (done8 === 1'b1) nd++;
    end
    checks++;
    if (nd !== 0) begin
      errors++;
      $display("FAIL busy_extra_done: got %0d pulses want 0", nd);
    end
  endtask

  task automatic test_reset_mid();
    int lat, nb, nd;
    logic [8:0] exp;
    a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (busy8 !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_busy_before: got %b want 1", busy8);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({busy8, done8, cout8, sum8} !== 11'd0) begin
      errors++;
      $display("FAIL rstmid_async_clear: got %h want 000", {busy8, done8, cout8, sum8});
    end
    nd = 0;
    repeat (3) begin
      tick();
      if (done8 === 1'b1) nd++;
    end
    rst = 1'b0;
    repeat (10) begin
      tick();
      if (done8 === 1'b1) nd++;
    end
    checks++;
    if (nd !== 0) begin
      errors++;
      $display("FAIL rstmid_no_done: got %0d pulses want 0", nd);
    end
    op8(8'h12, 8'h34, 1'b1, lat, nb);
    exp = q8.pop_front();
    checks++;
    if ({cout8, sum8} !== exp || lat !== 8) begin
      errors++;
      $display("FAIL rstmid_next_op: got %h lat %0d want %h lat 8", {cout8, sum8}, lat, exp);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [8:0] exp;
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    q8.push_back(9'h030);
    tick();
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
    q8.push_back(9'h100);
    lat = 0;
    while (done8 !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    exp = q8.pop_front();
    checks++;
    if ({cout8, sum8} !== exp || lat !== 8) begin
      errors++;
      $display("FAIL b2b_first: got %h lat %0d want %h lat 8", {cout8, sum8}, lat, exp);
    end
    tick();
    start8 = 1'b0;
    checks++;
    if (busy8 !== 1'b1 || {cout8, sum8} !== exp) begin
      errors++;
      $display("FAIL b2b_restart_hold: busy %b sum %h want busy 1 sum %h", busy8, {cout8, sum8}, exp);
    end
    lat = 0;
    while (done8 !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    exp = q8.pop_front();
    checks++;
    if ({cout8, sum8} !== exp || lat !== 8) begin
      errors++;
      $display("FAIL b2b_second: got %h lat %0d want %h lat 8", {cout8, sum8}, lat, exp);
    end
    tick();
  endtask

  task automatic test_random8();
    int lat, nb;
    logic [8:0] exp;
    for (int i = 0; i < 1000; i++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom), lat, nb);
      exp = q8.pop_front();
      checks++;
      if (done8 !== 1'b1 || {cout8, sum8} !== exp) begin
        errors++;
        $display("FAIL rand8 #%0d: got %h done %b want %h", i, {cout8, sum8}, done8, exp);
      end
      if ($urandom_range(0, 1) == 1) tick();
    end
    tick();
  endtask

  task automatic test_random2();
    int lat;
    logic [2:0] exp;
    for (int i = 0; i < 300; i++) begin
      a2 = 2'($urandom); b2 = 2'($urandom); cin2 = 1'($urandom); start2 = 1'b1;
      q2.push_back({1'b0, a2} + {1'b0, b2} + 3'(cin2));
      tick();
      start2 = 1'b0;
      lat = 0;
      while (done2 !== 1'b1 && lat < 20) begin
        tick();
        lat++;
      end
      exp = q2.pop_front();
      checks++;
      if (lat !== 2 || {cout2, sum2} !== exp) begin
        errors++;
        $display("FAIL rand2 #%0d: got %h lat %0d want %h lat 2", i, {cout2, sum2}, lat, exp);
      end
      if ($urandom_range(0, 1) == 1) tick();
    end
    tick();
  endtask

  task automatic test_random16();
    int lat;
    logic [16:0] exp;
    for (int i = 0; i < 300; i++) begin
      a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom); start16 = 1'b1;
      if (i == 0) begin
        a16 = 16'hFFFF; b16 = 16'h0001; cin16 = 1'b0;
      end
      q16.push_back({1'b0, a16} + {1'b0, b16} + 17'(cin16));
      tick();
      start16 = 1'b0;
      lat = 0;
      while (done16 !== 1'b1 && lat < 40) begin
        tick();
        lat++;
      end
      exp = q16.pop_front();
      checks++;
      if (lat !== 16 || {cout16, sum16} !== exp) begin
        errors++;
        $display("FAIL rand16 #%0d: got %h lat %0d want %h lat 16", i, {cout16, sum16}, lat, exp);
      end
      if ($urandom_range(0, 1) == 1) tick();
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_full_adder();
    test_basic();
    test_wrap();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    test_random8();
    test_random2();
    test_random16();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
